// File: rtl/ctrl_pipe_chain.sv
// Control-word pipeline from decode through STAGES downstream stages.
// Per-stage valid, stall backpressure, bubble insertion, flush and bubble counter.
module ctrl_pipe_chain #(
    parameter int              WIDTH  = 44,
    parameter int              STAGES = 3,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int              CNT_W  = 16,
    localparam int             IW     = $clog2(STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          in_word,
    input  logic                      in_valid,
    input  logic [STAGES-1:0]         stall,
    input  logic [STAGES-1:0]         flush,
    input  logic                      cnt_clr,
    output logic [STAGES*WIDTH-1:0]   stage_word,
    output logic [STAGES-1:0]         stage_valid,
    output logic [STAGES-1:0]         stall_eff,
    output logic [IW-1:0]             inflight,
    output logic [CNT_W-1:0]          bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [STAGES-1:0] ins;
    logic              bubble_any;

    // A stall anywhere downstream also freezes every stage above it.
    always_comb begin : eff_chain
        logic acc;
        acc       = 1'b0;
        stall_eff = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc          = acc | stall[i];
            stall_eff[i] = acc;
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : st
        logic [WIDTH-1:0] w_q;
        logic             v_q;
        logic [WIDTH-1:0] src_w;
        logic             src_v;
        logic             src_st;

        if (g == 0) begin : src_dec
            assign src_w  = in_word;
            assign src_v  = in_valid;
            assign src_st = 1'b0;
        end else begin : src_up
            assign src_w  = stage_word[(g-1)*WIDTH +: WIDTH];
            assign src_v  = stage_valid[g-1];
            assign src_st = stall_eff[g-1];
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                w_q <= BUBBLE;
                v_q <= 1'b0;
            end else if (flush[g]) begin
                w_q <= BUBBLE;
                v_q <= 1'b0;
            end else if (stall_eff[g]) begin
                w_q <= w_q;
                v_q <= v_q;
            end else if (src_st) begin
                w_q <= BUBBLE;
                v_q <= 1'b0;
            end else begin
                w_q <= src_w;
                v_q <= src_v;
            end
        end

        assign stage_word[g*WIDTH +: WIDTH] = w_q;
        assign stage_valid[g]               = v_q;
        assign ins[g] = ~flush[g] & ~stall_eff[g] & src_st;
    end

    assign bubble_any = |ins;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            bubble_cnt <= '0;
        end else if (bubble_any && bubble_cnt != CNT_MAX) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < STAGES; i++) begin
            inflight = inflight + IW'(stage_valid[i]);
        end
    end

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Scoreboard bench for ctrl_pipe_chain: directed scenarios plus random traffic
// checked against an array-based reference model.
module tb_ctrl_pipe_chain;

    localparam int W  = 8;
    localparam int S  = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in_word;
    logic          in_valid;
    logic [S-1:0]  stall;
    logic [S-1:0]  flush;
    logic          cnt_clr;
    logic [S*W-1:0] stage_word;
    logic [S-1:0]  stage_valid;
    logic [S-1:0]  stall_eff;
    logic [1:0]    inflight;
    logic [CW-1:0] bubble_cnt;

    ctrl_pipe_chain #(
        .WIDTH(W), .STAGES(S), .BUBBLE(8'h00), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid),
        .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .stage_word(stage_word), .stage_valid(stage_valid),
        .stall_eff(stall_eff), .inflight(inflight), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] words;
        logic [2:0]  valid;
        logic [2:0]  eff;
        logic [1:0]  infl;
        logic [3:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    logic [7:0] m_w[3];
    logic       m_v[3];
    int         m_cnt;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Stage i is frozen when any stall bit at i or further downstream is set.
    function automatic logic [2:0] ref_eff(input logic [2:0] s);
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = (s >> i) != 3'b0;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_w[i] = 8'h00;
            m_v[i] = 1'b0;
        end
        m_cnt = 0;
    endtask

    task automatic model_step(input logic [7:0] w, input logic v,
                              input logic [2:0] s, input logic [2:0] f,
                              input logic clr);
        logic [2:0] e;
        logic [7:0] nw[3];
        logic       nv[3];
        bit         bub;
        e   = ref_eff(s);
        bub = 0;
        for (int i = 0; i < 3; i++) begin
            if (f[i]) begin
                nw[i] = 8'h00; nv[i] = 1'b0;
            end else if (e[i]) begin
                nw[i] = m_w[i]; nv[i] = m_v[i];
            end else if (i > 0 && e[i-1]) begin
                nw[i] = 8'h00; nv[i] = 1'b0; bub = 1;
            end else if (i == 0) begin
                nw[i] = w; nv[i] = v;
            end else begin
                nw[i] = m_w[i-1]; nv[i] = m_v[i-1];
            end
        end
        for (int i = 0; i < 3; i++) begin
            m_w[i] = nw[i];
            m_v[i] = nv[i];
        end
        if (clr) m_cnt = 0;
        else if (bub) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
    endtask

    function automatic exp_t snap(input logic [2:0] s);
        exp_t x;
        x.words = {m_w[2], m_w[1], m_w[0]};
        x.valid = {m_v[2], m_v[1], m_v[0]};
        x.eff   = ref_eff(s);
        x.infl  = 2'(int'(m_v[0]) + int'(m_v[1]) + int'(m_v[2]));
        x.cnt   = 4'(m_cnt);
        return x;
    endfunction

    task automatic cyc(input logic r, input logic [7:0] w, input logic v,
                       input logic [2:0] s, input logic [2:0] f,
                       input logic clr);
        @(posedge clk);
        #1;
        rst = r; in_word = w; in_valid = v;
        stall = s; flush = f; cnt_clr = clr;
        if (!r) begin
            #1;
            chk("async_rst_word", 32'(stage_word), 32'h0);
            chk("async_rst_valid", 32'(stage_valid), 32'h0);
            chk("async_rst_cnt", 32'(bubble_cnt), 32'h0);
            model_reset();
        end
        sb.push_back(snap(s));
        if (r) model_step(w, v, s, f, clr);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("stage_word", 32'(stage_word), 32'(e.words));
                chk("stage_valid", 32'(stage_valid), 32'(e.valid));
                chk("stall_eff", 32'(stall_eff), 32'(e.eff));
                chk("inflight", 32'(inflight), 32'(e.infl));
                chk("bubble_cnt", 32'(bubble_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin : driver
        logic [7:0] held;
        logic       hold;
        logic [2:0] s, f;

        rst = 1'b0; in_word = '0; in_valid = 1'b0;
        stall = '0; flush = '0; cnt_clr = 1'b0;
        model_reset();
        #1;
        chk("reset_word", 32'(stage_word), 32'h0);
        chk("reset_valid", 32'(stage_valid), 32'h0);
        chk("reset_cnt", 32'(bubble_cnt), 32'h0);

        // streaming then a mid-pipe stall
        cyc(1, 8'h11, 1, 3'b000, 3'b000, 0);
        cyc(1, 8'h22, 1, 3'b000, 3'b000, 0);
        cyc(1, 8'h33, 1, 3'b000, 3'b000, 0);
        cyc(1, 8'h44, 1, 3'b010, 3'b000, 0);
        #3;
        chk("stream_s2", 32'(stage_word[23:16]), 32'h11);
        chk("stream_inflight", 32'(inflight), 32'd3);
        chk("stall_eff_011", 32'(stall_eff), 32'b011);
        cyc(1, 8'h44, 1, 3'b000, 3'b000, 0);
        #3;
        chk("stall_words", 32'(stage_word), 32'h002233);
        chk("stall_valid", 32'(stage_valid), 32'b011);
        chk("stall_cnt", 32'(bubble_cnt), 32'd1);

        // flush beats stall on stage 0
        cyc(1, 8'h55, 1, 3'b111, 3'b001, 0);
        cyc(1, 8'h55, 1, 3'b000, 3'b000, 0);
        #3;
        chk("flush_stall_words", 32'(stage_word), 32'h223300);
        chk("flush_stall_valid", 32'(stage_valid), 32'b110);
        chk("flush_stall_cnt", 32'(bubble_cnt), 32'd1);

        // counter saturation and clear priority
        for (int i = 0; i < 20; i++) cyc(1, 8'h66, 1, 3'b010, 3'b000, 0);
        cyc(1, 8'h66, 1, 3'b010, 3'b000, 1);
        #3;
        chk("sat_cnt", 32'(bubble_cnt), 32'hF);
        cyc(1, 8'h66, 1, 3'b010, 3'b000, 0);
        #3;
        chk("clr_cnt", 32'(bubble_cnt), 32'h0);
        cyc(1, 8'h66, 1, 3'b000, 3'b000, 0);
        #3;
        chk("after_clr_cnt", 32'(bubble_cnt), 32'h1);

        // full flush under streaming
        cyc(1, 8'hA1, 1, 3'b000, 3'b000, 0);
        cyc(1, 8'hA2, 1, 3'b000, 3'b000, 0);
        cyc(1, 8'hA3, 1, 3'b000, 3'b111, 0);
        cyc(1, 8'hA4, 1, 3'b000, 3'b000, 0);
        #3;
        chk("fullflush_valid", 32'(stage_valid), 32'h0);
        chk("fullflush_inflight", 32'(inflight), 32'h0);

        // asynchronous reset with a full pipe
        cyc(1, 8'hB1, 1, 3'b000, 3'b000, 0);
        cyc(1, 8'hB2, 1, 3'b000, 3'b000, 0);
        cyc(1, 8'hB3, 1, 3'b000, 3'b000, 0);
        cyc(1, 8'hB4, 1, 3'b000, 3'b000, 0);
        #3;
        chk("prefill_valid", 32'(stage_valid), 32'b111);
        cyc(0, 8'hB5, 1, 3'b000, 3'b000, 0);
        cyc(1, 8'hB6, 1, 3'b000, 3'b000, 0);

        // random traffic; decode holds its word while stage 0 is frozen
        held = 8'h00;
        hold = 1'b0;
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < 3; b++) begin
                s[b] = ($urandom_range(0, 4) == 0);
                f[b] = ($urandom_range(0, 9) == 0);
            end
            if (!hold) held = 8'($urandom);
            cyc(($urandom_range(0, 99) != 0), held,
                1'($urandom), s, f, ($urandom_range(0, 29) == 0));
            hold = ref_eff(s)[0];
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
